// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program-counter stage of the RISC core. Registers the next address chosen
//   by the upstream next-PC mux, drives the instruction-memory address, and
//   hands pc+1 back to that mux. It also owns a small return-address stack
//   (RAS) for call/ret, and a BOOT/RUN/HALT sequencer that gates fetch.
//
// Ports
//   clk            in   1       system clock, rising edge
//   rst            in   1       asynchronous active-high reset
//   i_next_pc      in   ADDR_W  next address from the next-PC mux
//   i_stall        in   1       hold PC; ignore call/ret/halt this cycle
//   i_call         in   1       push pc+1 onto the RAS (PC still takes next_pc)
//   i_ret          in   1       redirect PC to the RAS top and pop
//   i_halt         in   1       enter HALT; fetch stops
//   o_pc           out  ADDR_W  current instruction address (registered)
//   o_pc_plus1     out  ADDR_W  pc+1 modulo 2^ADDR_W (combinational)
//   o_fetch_valid  out  1       pc addresses a live instruction (RUN only)
//   o_halted       out  1       high while in HALT
//   o_ras_err      out  1       sticky RAS overflow/underflow flag
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int          ADDR_W    = 10,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_next_pc,
  input  logic              i_stall,
  input  logic              i_call,
  input  logic              i_ret,
  input  logic              i_halt,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus1,
  output logic              o_fetch_valid,
  output logic              o_halted,
  output logic              o_ras_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  // One extra bit so the count can represent a completely full stack.
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic              w_take;
  logic              w_call;
  logic              w_ret;
  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_top_idx;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_err_set;
  logic              w_push;
  logic [PTR_W-1:0]  w_push_idx;

  // Wraps naturally at 2^ADDR_W.
  assign w_pc_plus1 = r_pc + PC_ONE;

  // A cycle only does work in RUN, unstalled, and not halting; halt wins over
  // call/ret so the PC freezes on the halting instruction.
  assign w_take  = (r_state == ST_RUN) && !i_stall && !i_halt;
  assign w_call  = w_take && i_call;
  assign w_ret   = w_take && i_ret;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  // Only meaningful when the stack is non-empty.
  assign w_top_idx = PTR_W'(r_count - CNT_ONE);

  // Sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer: next state. BOOT is a single bubble cycle; HALT only exits
  // through reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (i_halt && !i_stall) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Next PC and stack bookkeeping.
  always_comb begin
    w_pc_nxt   = r_pc;
    w_cnt_nxt  = r_count;
    w_err_set  = 1'b0;
    w_push     = 1'b0;
    w_push_idx = w_top_idx;
    if (w_take) begin
      w_pc_nxt = i_next_pc;
      if (w_ret) begin
        if (w_empty) begin
          // Underflow: fall through to next_pc. A simultaneous call still
          // lands in slot 0.
          w_err_set = 1'b1;
          if (w_call) begin
            w_push     = 1'b1;
            w_push_idx = '0;
            w_cnt_nxt  = CNT_ONE;
          end
        end else begin
          w_pc_nxt = r_ras[w_top_idx];
          if (w_call) begin
            // Pop and push cancel: overwrite the top in place, so this can
            // never overflow even on a full stack.
            w_push     = 1'b1;
            w_push_idx = w_top_idx;
          end else begin
            w_cnt_nxt = r_count - CNT_ONE;
          end
        end
      end else if (w_call) begin
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_push     = 1'b1;
          w_push_idx = PTR_W'(r_count);
          w_cnt_nxt  = r_count + CNT_ONE;
        end
      end
    end
  end

  // Control state: PC, stack depth, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= PC_RST;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_count <= w_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Stack storage carries no reset; the depth count defines what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_push_idx] <= w_pc_plus1;
  end

  assign o_pc          = r_pc;
  assign o_pc_plus1    = w_pc_plus1;
  assign o_fetch_valid = (r_state == ST_RUN);
  assign o_halted      = (r_state == ST_HALT);
  assign o_ras_err     = r_err;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic       clk;
  logic       rst;
  logic [9:0] next_pc;
  logic       stall;
  logic       call;
  logic       ret;
  logic       halt;
  logic [9:0] pc;
  logic [9:0] pc_plus1;
  logic       fetch_valid;
  logic       halted;
  logic       ras_err;

  int n_checks;
  int n_errors;

  pc_unit #(
    .ADDR_W   (10),
    .RAS_DEPTH(4),
    .RESET_PC (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_next_pc    (next_pc),
    .i_stall      (stall),
    .i_call       (call),
    .i_ret        (ret),
    .i_halt       (halt),
    .o_pc         (pc),
    .o_pc_plus1   (pc_plus1),
    .o_fetch_valid(fetch_valid),
    .o_halted     (halted),
    .o_ras_err    (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; call = 0; ret = 0; halt = 0;
  endtask

  // Reset, release, and step through the BOOT bubble into RUN at pc=0.
  task automatic reset_to_run();
    idle_inputs();
    next_pc = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  // One plain cycle with the given next address.
  task automatic go(input logic [9:0] a);
    next_pc = a;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    next_pc = 0;

    // ---- 1 reset / boot ----
    rst = 1;
    tick();
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", ras_err, 0);
    rst = 0;
    next_pc = 9;            // BOOT must ignore this
    #1;
    chk("boot_fv", fetch_valid, 0);
    tick();
    chk("boot_pc_held", pc, 0);
    chk("run_fv", fetch_valid, 1);
    go(1); chk("step_pc1", pc, 1);
    go(2); chk("step_pc2", pc, 2);
    go(3); chk("step_pc3", pc, 3);
    chk("step_plus1", pc_plus1, 4);

    // ---- 2 stall / branch ----
    go(4);
    go(5); chk("pre_stall_pc", pc, 5);
    stall = 1;
    next_pc = 40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 5);
      chk("stall_fv", fetch_valid, 1);
    end
    stall = 0;
    tick();
    chk("branch_pc", pc, 40);

    // ---- 3 call / ret ----
    go(10); chk("call_src_pc", pc, 10);
    call = 1; go(100); call = 0;
    chk("call_tgt_pc", pc, 100);
    ret = 1; go(200);
    chk("ret_pc", pc, 11);
    chk("ret_no_err", ras_err, 0);
    go(50);
    chk("underflow_pc", pc, 50);
    chk("underflow_err", ras_err, 1);
    ret = 0;
    go(51);
    chk("err_sticky", ras_err, 1);

    // ---- 4 overflow ----
    reset_to_run();
    chk("rst2_err", ras_err, 0);
    go(1);
    call = 1;
    go(2); go(3); go(4); go(5);
    chk("full_no_err", ras_err, 0);
    go(6);
    call = 0;
    chk("overflow_err", ras_err, 1);
    chk("overflow_pc", pc, 6);
    ret = 1;
    go(600); chk("pop1", pc, 5);
    go(600); chk("pop2", pc, 4);
    go(600); chk("pop3", pc, 3);
    go(600); chk("pop4", pc, 2);
    ret = 0;

    // ---- 5 wrap + call&&ret ----
    reset_to_run();
    go(6);
    call = 1; go(300); call = 0;       // pushes 7
    go(1023);
    chk("wrap_pc", pc, 1023);
    chk("wrap_plus1", pc_plus1, 0);
    call = 1; ret = 1; go(400);        // top 7 -> pc, top becomes 0
    call = 0;
    chk("callret_pc", pc, 7);
    chk("callret_no_err", ras_err, 0);
    go(500);                           // ret: pops the rewritten top
    chk("callret_top", pc, 0);
    chk("callret_cnt_err", ras_err, 0);
    go(77);                            // stack now empty
    chk("callret_empty_pc", pc, 77);
    chk("callret_empty_err", ras_err, 1);
    ret = 0;
    // call&&ret on an empty stack: underflow, but the push still lands
    reset_to_run();
    go(30);
    call = 1; ret = 1; go(88);
    call = 0;
    chk("cr_empty_pc", pc, 88);
    chk("cr_empty_err", ras_err, 1);
    go(90);
    ret = 0;
    chk("cr_empty_pushed", pc, 31);

    // ---- 6 halt / reset ----
    reset_to_run();
    ret = 1; go(20); ret = 0;          // underflow sets the sticky error
    chk("pre_halt_pc", pc, 20);
    chk("pre_halt_err", ras_err, 1);
    stall = 1; halt = 1; go(21);       // stalled halt is ignored
    stall = 0;
    chk("stall_halt_pc", pc, 20);
    chk("stall_halt_state", halted, 0);
    call = 1; go(99);                  // halt wins over call
    call = 0; halt = 0;
    chk("halt_pc", pc, 20);
    chk("halt_flag", halted, 1);
    chk("halt_fv", fetch_valid, 0);
    go(33); go(34);
    chk("halt_hold_pc", pc, 20);
    chk("halt_hold_flag", halted, 1);
    chk("halt_hold_fv", fetch_valid, 0);
    rst = 1;
    #2;                                // asynchronous: no clock edge needed
    chk("async_rst_pc", pc, 0);
    chk("async_rst_halted", halted, 0);
    chk("async_rst_fv", fetch_valid, 0);
    chk("async_rst_err", ras_err, 0);
    tick();
    rst = 0;
    tick();
    chk("after_rst_fv", fetch_valid, 1);
    chk("after_rst_pc", pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
